// File: rtl/sound_pkg.sv
// Shared definitions for the sound mixer.
// Provides the sample/gain widths, the mixer FSM state type, and the 16-bit
// saturation helpers used on the mixer output.
package sound_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int GAIN_W      = 4;
    // Gain code 8 is unity, so each product is shifted right by 3.
    localparam int UNITY_SHIFT = 3;

    localparam int SAT_MAX = (1 << (SAMPLE_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (SAMPLE_W - 1));

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StFilter,
        StSat
    } mixer_state_t;

    // Clamp a signed value into the signed 16-bit range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
        if (v > SAT_MAX) begin
            return SAMPLE_W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return SAMPLE_W'(SAT_MIN);
        end
        return SAMPLE_W'(v);
    endfunction

    // True when sat16() would have to clamp v.
    function automatic logic clip16(input logic signed [31:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

endpackage

// File: rtl/sound_mixer.sv
// Multi-voice sound mixer.
// One time-shared multiply-accumulate sums NUM_CH signed 16-bit voices per
// 48 kHz strobe, each scaled by a 4-bit gain (8 = unity) and optionally muted.
// A first-order DC estimator (time constant 2^DC_SHIFT samples) is subtracted
// unless bypassed, and the result is saturated to 16 bits and registered.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   clk_en_48KHz  one-clk sample strobe; inputs are snapshotted on it
//   ch_in         NUM_CH signed 16-bit voice samples (ch0 = bang/crash voice)
//   ch_gain       NUM_CH unsigned 4-bit gains, 8 = unity
//   ch_mute       per-channel mute, 1 = contributes exactly 0
//   dc_bypass     1 = skip DC removal (estimator still tracks)
//   out           signed mixed sample, held until the next update
//   out_valid     one-clk pulse when out updates
//   clip          current out was saturated
//   overrun       sticky: a strobe arrived while a sample was in progress
module sound_mixer
    import sound_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DC_SHIFT = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clk_en_48KHz,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  ch_in,
    input  logic [NUM_CH-1:0][GAIN_W-1:0]    ch_gain,
    input  logic [NUM_CH-1:0]                ch_mute,
    input  logic                             dc_bypass,
    output logic signed [SAMPLE_W-1:0]       out,
    output logic                             out_valid,
    output logic                             clip,
    output logic                             overrun
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Signed sample times zero-extended gain.
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int TERM_W = PROD_W - UNITY_SHIFT;
    // Headroom for NUM_CH full-scale terms, so the sum cannot wrap.
    localparam int ACC_W  = TERM_W + $clog2(NUM_CH);
    localparam int HP_W   = ACC_W + 1;
    localparam int DC_W   = ACC_W + DC_SHIFT + 1;

    mixer_state_t                      r_state;
    mixer_state_t                      w_state_next;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]   r_samp;
    logic [NUM_CH-1:0][GAIN_W-1:0]     r_gain;
    logic [NUM_CH-1:0]                 r_mute;
    logic                              r_bypass;
    logic [IDX_W-1:0]                  r_idx;
    logic signed [ACC_W-1:0]           r_acc;
    logic signed [DC_W-1:0]            r_dc;
    logic signed [HP_W-1:0]            r_hp;
    logic signed [SAMPLE_W-1:0]        r_out;
    logic                              r_out_valid;
    logic                              r_clip;
    logic                              r_overrun;

    logic signed [SAMPLE_W-1:0]        w_samp;
    logic signed [PROD_W-1:0]          w_prod;
    logic signed [TERM_W-1:0]          w_term;
    logic signed [DC_W-1:0]            w_d;
    logic signed [HP_W-1:0]            w_hp;
    logic signed [DC_W-1:0]            w_dc_next;

    // MAC operand for the channel selected by r_idx.
    assign w_samp = $signed(r_samp[r_idx]);
    assign w_prod = w_samp * $signed({1'b0, r_gain[r_idx]});
    // Dropping the low bits of a signed product is a floor division by 8.
    assign w_term = r_mute[r_idx] ? '0 : w_prod[PROD_W-1:UNITY_SHIFT];

    // DC estimator: r_dc holds the running mean scaled by 2^DC_SHIFT.
    assign w_d       = r_dc >>> DC_SHIFT;
    assign w_hp      = r_bypass ? HP_W'(r_acc) : HP_W'(r_acc) - HP_W'(w_d);
    assign w_dc_next = r_dc + DC_W'(r_acc) - w_d;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (clk_en_48KHz) w_state_next = StAccum;
            StAccum:  if (r_idx == IDX_W'(NUM_CH - 1)) w_state_next = StFilter;
            StFilter: w_state_next = StSat;
            StSat:    w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_samp      <= '0;
            r_gain      <= '0;
            r_mute      <= '0;
            r_bypass    <= 1'b0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_dc        <= '0;
            r_hp        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_clip      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= 1'b0;
            // Strobes are only accepted in idle; anything else is dropped and flagged.
            if (clk_en_48KHz && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (clk_en_48KHz) begin
                        r_samp   <= ch_in;
                        r_gain   <= ch_gain;
                        r_mute   <= ch_mute;
                        r_bypass <= dc_bypass;
                        r_acc    <= '0;
                        r_idx    <= '0;
                    end
                end
                StAccum: begin
                    r_acc <= r_acc + ACC_W'(w_term);
                    r_idx <= r_idx + IDX_W'(1);
                end
                StFilter: begin
                    r_hp <= w_hp;
                    r_dc <= w_dc_next;
                end
                StSat: begin
                    r_out       <= sat16(32'(r_hp));
                    r_clip      <= clip16(32'(r_hp));
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign clip      = r_clip;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sound_mixer.sv
// Self-checking bench for sound_mixer: an integer model computes every
// expected sample from the mixing rules, a compare process checks out_valid
// on every cycle and out/clip on every valid pulse, and directed tests add
// hand-computed literal expectations.
module tb_sound_mixer;

    localparam int NUM_CH   = 4;
    localparam int DC_SHIFT = 8;

    logic                    clk;
    logic                    reset_n;
    logic                    clk_en_48KHz;
    logic [NUM_CH-1:0][15:0] ch_in;
    logic [NUM_CH-1:0][3:0]  ch_gain;
    logic [NUM_CH-1:0]       ch_mute;
    logic                    dc_bypass;
    logic signed [15:0]      out;
    logic                    out_valid;
    logic                    clip;
    logic                    overrun;

    sound_mixer #(
        .NUM_CH   (NUM_CH),
        .DC_SHIFT (DC_SHIFT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_en_48KHz (clk_en_48KHz),
        .ch_in        (ch_in),
        .ch_gain      (ch_gain),
        .ch_mute      (ch_mute),
        .dc_bypass    (dc_bypass),
        .out          (out),
        .out_valid    (out_valid),
        .clip         (clip),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int due;
        int val;
        bit clp;
    } exp_t;

    exp_t   exp_q[$];
    longint model_dc = 0;

    task automatic chk(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Floor division by 2^sh on plain integers.
    function automatic longint fdiv(input longint a, input int sh);
        longint den;
        longint q;
        den = longint'(1) << sh;
        q   = a / den;
        if ((a < 0) && ((a % den) != 0)) q = q - 1;
        return q;
    endfunction

    // Per-cycle compare: out_valid exactly when a model sample is due.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if ((exp_q.size() > 0) && (cyc == exp_q[0].due)) begin
                chk("valid_pulse", out_valid, 1);
                chk("out_value", out, exp_q[0].val);
                chk("clip_flag", clip, exp_q[0].clp);
                void'(exp_q.pop_front());
            end else begin
                chk("valid_idle", out_valid, 0);
            end
        end
    end

    // Compute expected result, drive one strobe, then scramble the inputs so
    // the snapshot is exercised. Ends one negedge after the strobe.
    task automatic launch(input int s[NUM_CH], input int g[NUM_CH],
                          input logic [NUM_CH-1:0] m, input logic byp);
        exp_t   e;
        longint acc;
        longint d;
        longint hp;
        @(negedge clk);
        acc = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!m[i]) acc += fdiv(longint'(s[i]) * g[i], 3);
        end
        d        = fdiv(model_dc, DC_SHIFT);
        hp       = byp ? acc : acc - d;
        model_dc = model_dc + acc - d;
        e.val = (hp > 32767) ? 32767 : (hp < -32768) ? -32768 : int'(hp);
        e.clp = (hp > 32767) || (hp < -32768);
        e.due = cyc + NUM_CH + 3;
        exp_q.push_back(e);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_in[i]   = 16'(s[i]);
            ch_gain[i] = 4'(g[i]);
        end
        ch_mute      = m;
        dc_bypass    = byp;
        clk_en_48KHz = 1'b1;
        @(negedge clk);
        clk_en_48KHz = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_in[i]   = 16'($urandom);
            ch_gain[i] = 4'($urandom);
        end
        ch_mute   = 4'($urandom);
        dc_bypass = 1'($urandom);
    endtask

    task automatic send(input int s[NUM_CH], input int g[NUM_CH],
                        input logic [NUM_CH-1:0] m, input logic byp);
        launch(s, g, m, byp);
        repeat (NUM_CH + 3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        model_dc = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_clip", clip, 0);
        chk("rst_overrun", overrun, 0);
        clk_en_48KHz = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (NUM_CH + 4) @(negedge clk);
    endtask

    int s[NUM_CH];
    int g[NUM_CH];
    int prev;

    initial begin
        reset_n      = 1'b0;
        clk_en_48KHz = 1'b1;
        ch_in        = '1;
        ch_gain      = '1;
        ch_mute      = '0;
        dc_bypass    = 1'b1;

        // 1: reset with a strobe held high, then idle with no output.
        do_reset();

        // 2: unity gain on ch0 only.
        s = '{1000, 5, 6, 7};
        g = '{8, 8, 8, 8};
        send(s, g, 4'b1110, 1'b1);
        chk("unity_out", out, 1000);
        chk("unity_clip", clip, 0);

        // 3: mixed gains with a negative floored term.
        s = '{1000, -1001, 12345, -222};
        g = '{15, 3, 0, 0};
        send(s, g, 4'b0000, 1'b1);
        chk("mix_out", out, 1499);

        // 4: saturation both ways, then recovery.
        s = '{30000, 30000, 30000, 30000};
        g = '{15, 15, 15, 15};
        send(s, g, 4'b0000, 1'b1);
        chk("sat_hi_out", out, 32767);
        chk("sat_hi_clip", clip, 1);
        s = '{-30000, -30000, -30000, -30000};
        send(s, g, 4'b0000, 1'b1);
        chk("sat_lo_out", out, -32768);
        chk("sat_lo_clip", clip, 1);
        s = '{100, 0, 0, 0};
        g = '{8, 0, 0, 0};
        send(s, g, 4'b0000, 1'b1);
        chk("recover_out", out, 100);
        chk("recover_clip", clip, 0);
        chk("no_overrun_yet", overrun, 0);

        // 5: second strobe two clocks into a sample is dropped.
        s = '{500, 0, 0, 0};
        g = '{8, 8, 8, 8};
        launch(s, g, 4'b1110, 1'b1);
        @(negedge clk);
        ch_in[0]     = 16'(-7000);
        ch_gain[0]   = 4'd8;
        ch_mute      = '0;
        clk_en_48KHz = 1'b1;
        @(negedge clk);
        clk_en_48KHz = 1'b0;
        repeat (NUM_CH + 1) @(negedge clk);
        chk("overrun_out", out, 500);
        chk("overrun_set", overrun, 1);
        s = '{-40, 0, 0, 0};
        send(s, g, 4'b0000, 1'b1);
        chk("overrun_next_out", out, -40);
        chk("overrun_sticky", overrun, 1);
        do_reset();

        // 6: DC removal on a held step decays toward zero.
        s = '{8192, 1, 2, 3};
        g = '{8, 8, 8, 8};
        prev = 32767;
        for (int n = 0; n < 1280; n++) begin
            send(s, g, 4'b1110, 1'b0);
            if (n == 0) chk("dc_first_out", out, 8192);
            else chk("dc_monotonic", ($signed(out) <= prev) && ($signed(out) >= 0), 1);
            prev = int'($signed(out));
        end
        chk("dc_below_64", (prev < 64) && (prev > -64), 1);

        // Reset mid-accumulate: no output for the aborted sample.
        @(negedge clk);
        ch_in[0]     = 16'd4000;
        clk_en_48KHz = 1'b1;
        @(negedge clk);
        clk_en_48KHz = 1'b0;
        @(negedge clk);
        reset_n  = 1'b0;
        model_dc = 0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_out", out, 0);
        reset_n = 1'b1;
        repeat (NUM_CH + 6) @(negedge clk);
        // The estimator restarts from zero, so the step passes unchanged.
        send(s, g, 4'b1110, 1'b0);
        chk("dc_restart_out", out, 8192);
        chk("dc_restart_overrun", overrun, 0);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
